// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the fetch pipeline: instruction codes,
// status codes and the "no register" identifier.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/y86_instr_split.sv
// Splits a 10-byte little-endian instruction window into its Y86-64 fields.
module y86_instr_split
  import y86_pkg::*;
(
  input  logic [79:0] window,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [63:0] valc,
  output logic        need_regids,
  output logic        need_valc,
  output logic        instr_valid
);

  always_comb begin
    icode       = window[7:4];
    ifun        = window[3:0];
    need_regids = icode inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ};
    need_valc   = icode inside {IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL};
    instr_valid = (icode <= IPOPQ);
    ra          = need_regids ? window[15:12] : RNONE;
    rb          = need_regids ? window[11:8]  : RNONE;
    // The constant word follows the register byte when one is present.
    if (!need_valc)
      valc = '0;
    else if (need_regids)
      valc = window[79:16];
    else
      valc = window[71:8];
  end

endmodule

// File: rtl/y86_fetch_pipe.sv
// Pipelined Y86-64 fetch: PC select, byte-addressed instruction memory,
// decode of length/registers/constant, next-PC prediction and D register.
module y86_fetch_pipe
  import y86_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_BYTES)-1:0] imem_waddr,
  input  logic [7:0]                    imem_wdata,
  input  logic                          F_stall,
  input  logic                          D_stall,
  input  logic                          D_bubble,
  input  logic [3:0]                    M_icode,
  input  logic                          M_Cnd,
  input  logic [63:0]                   M_valA,
  input  logic [3:0]                    W_icode,
  input  logic [63:0]                   W_valM,
  output logic [63:0]                   f_pc,
  output logic [2:0]                    D_stat,
  output logic [3:0]                    D_icode,
  output logic [3:0]                    D_ifun,
  output logic [3:0]                    D_rA,
  output logic [3:0]                    D_rB,
  output logic [63:0]                   D_valC,
  output logic [63:0]                   D_valP
);

  localparam int unsigned AW = $clog2(IMEM_BYTES);

  logic [7:0]  imem [IMEM_BYTES];
  logic [63:0] f_pred_pc;
  logic [79:0] window;
  logic [3:0]  raw_icode, raw_ifun, raw_ra, raw_rb;
  logic [63:0] raw_valc;
  logic        need_regids, need_valc, instr_valid;
  logic [63:0] len, f_valp, pred_pc;
  logic        imem_error;
  logic [2:0]  f_stat;
  logic [3:0]  f_icode, f_ifun, f_ra, f_rb;
  logic [63:0] f_valc;

  // No reset on the memory: contents must survive reset and load during it.
  always_ff @(posedge clk) begin
    if (imem_we)
      imem[imem_waddr] <= imem_wdata;
  end

  always_comb begin
    if (M_icode == IJXX && !M_Cnd)
      f_pc = M_valA;
    else if (W_icode == IRET)
      f_pc = W_valM;
    else
      f_pc = f_pred_pc;
  end

  // Bytes past the end wrap in the index only; imem_error discards them.
  always_comb begin
    window = '0;
    for (int unsigned i = 0; i < 10; i++)
      window[i*8 +: 8] = imem[f_pc[AW-1:0] + AW'(i)];
  end

  y86_instr_split u_split (
    .window      (window),
    .icode       (raw_icode),
    .ifun        (raw_ifun),
    .ra          (raw_ra),
    .rb          (raw_rb),
    .valc        (raw_valc),
    .need_regids (need_regids),
    .need_valc   (need_valc),
    .instr_valid (instr_valid)
  );

  always_comb begin
    len        = 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);
    f_valp     = f_pc + len;
    imem_error = (f_pc >= 64'(IMEM_BYTES)) || ((f_pc + len) > 64'(IMEM_BYTES));
    f_stat     = SAOK;
    f_icode    = raw_icode;
    f_ifun     = raw_ifun;
    f_ra       = raw_ra;
    f_rb       = raw_rb;
    f_valc     = raw_valc;
    if (imem_error) begin
      f_stat  = SADR;
      f_icode = INOP;
      f_ifun  = 4'h0;
      f_ra    = RNONE;
      f_rb    = RNONE;
      f_valc  = '0;
    end else if (!instr_valid) begin
      f_stat = SINS;
    end else if (raw_icode == IHALT) begin
      f_stat = SHLT;
    end
    pred_pc = (f_icode == IJXX || f_icode == ICALL) ? f_valc : f_valp;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      f_pred_pc <= RESET_PC;
    else if (!F_stall)
      f_pred_pc <= pred_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || (!D_stall && D_bubble)) begin
      D_stat  <= SAOK;
      D_icode <= INOP;
      D_ifun  <= 4'h0;
      D_rA    <= RNONE;
      D_rB    <= RNONE;
      D_valC  <= '0;
      D_valP  <= '0;
    end else if (!D_stall) begin
      D_stat  <= f_stat;
      D_icode <= f_icode;
      D_ifun  <= f_ifun;
      D_rA    <= f_ra;
      D_rB    <= f_rb;
      D_valC  <= f_valc;
      D_valP  <= f_valp;
    end
  end

endmodule

// File: tb/tb_y86_fetch_pipe.sv
// Scoreboard bench for y86_fetch_pipe: directed program, expectations queued
// with the cycle they become due, checked by an independent negedge monitor.
module tb_y86_fetch_pipe;

  localparam int unsigned IMEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_we;
  logic [9:0]  imem_waddr;
  logic [7:0]  imem_wdata;
  logic        F_stall, D_stall, D_bubble;
  logic [3:0]  M_icode, W_icode;
  logic        M_Cnd;
  logic [63:0] M_valA, W_valM;
  logic [63:0] f_pc;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;

  y86_fetch_pipe #(.IMEM_BYTES(IMEM_BYTES), .RESET_PC(64'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .F_stall    (F_stall),
    .D_stall    (D_stall),
    .D_bubble   (D_bubble),
    .M_icode    (M_icode),
    .M_Cnd      (M_Cnd),
    .M_valA     (M_valA),
    .W_icode    (W_icode),
    .W_valM     (W_valM),
    .f_pc       (f_pc),
    .D_stat     (D_stat),
    .D_icode    (D_icode),
    .D_ifun     (D_ifun),
    .D_rA       (D_rA),
    .D_rB       (D_rB),
    .D_valC     (D_valC),
    .D_valP     (D_valP)
  );

  always #5 clk = ~clk;

  // kind: 0 = f_pc, 1 = full D register, 2 = D stat/icode/ifun only
  typedef struct {
    string       name;
    int unsigned due;
    int          kind;
    logic [63:0] pc;
    logic [2:0]  stat;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input exp_t e);
    logic ok;
    n_tests++;
    case (e.kind)
      0: ok = (f_pc === e.pc);
      1: ok = ({D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP} ===
               {e.stat, e.icode, e.ifun, e.ra, e.rb, e.valc, e.valp});
      default: ok = ({D_stat, D_icode, D_ifun} === {e.stat, e.icode, e.ifun});
    endcase
    if (!ok) begin
      n_fail++;
      if (e.kind == 0)
        $display("FAIL %s: f_pc got %h want %h", e.name, f_pc, e.pc);
      else
        $display("FAIL %s: D got stat=%0d icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h want stat=%0d icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h",
                 e.name, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
                 e.stat, e.icode, e.ifun, e.ra, e.rb, e.valc, e.valp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i]);
        sb.delete(i);
      end
    end
  end

  task automatic exp_f(input string n, input int unsigned due, input logic [63:0] pc);
    exp_t e;
    e.name = n; e.due = due; e.kind = 0; e.pc = pc;
    e.stat = '0; e.icode = '0; e.ifun = '0; e.ra = '0; e.rb = '0; e.valc = '0; e.valp = '0;
    sb.push_back(e);
  endtask

  task automatic exp_d(input string n, input int unsigned due, input int kind,
                       input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] vc, input logic [63:0] vp);
    exp_t e;
    e.name = n; e.due = due; e.kind = kind; e.pc = '0;
    e.stat = st; e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb; e.valc = vc; e.valp = vp;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [7:0] b);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = b;
    step();
    imem_we = 1'b0;
  endtask

  task automatic wr_word(input logic [9:0] a, input logic [63:0] w);
    for (int unsigned i = 0; i < 8; i++) wr(a + 10'(i), w[i*8 +: 8]);
  endtask

  task automatic pipe_defaults();
    F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
    M_icode = 4'h1; M_Cnd = 1'b1; M_valA = '0;
    W_icode = 4'h1; W_valM = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    pipe_defaults();
    step();
    // Program loaded while held in reset.
    wr(10'd0, 8'h30); wr(10'd1, 8'hF0); wr_word(10'd2, 64'd10);   // irmovq $10,%rax
    wr(10'd10, 8'h70); wr_word(10'd11, 64'h100);                  // jmp 0x100
    wr(10'd19, 8'h60); wr(10'd20, 8'h01);                         // addq %rax,%rcx
    wr(10'd21, 8'h90);                                            // ret
    wr(10'd30, 8'hE0);                                            // invalid
    wr(10'd31, 8'h90);                                            // ret
    wr(10'd256, 8'h00); wr(10'd257, 8'h00);                       // halt, halt
    wr(10'd1019, 8'h30); wr(10'd1020, 8'hF0);                     // truncated irmovq

    exp_f("reset_fpc", cyc, 64'h0);
    exp_d("reset_bubble", cyc, 1, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    step();

    rst_n = 1'b1;
    exp_f("fpc_start", cyc, 64'h0);
    exp_d("irmovq", cyc + 1, 1, 3'd1, 4'h3, 4'h0, 4'hF, 4'h0, 64'd10, 64'd10);
    step();

    exp_f("fpc_after_irmovq", cyc, 64'd10);
    exp_d("jmp", cyc + 1, 1, 3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h100, 64'd19);
    step();

    M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'd19; W_icode = 4'h9; W_valM = 64'h200;
    exp_f("mispredict_over_ret", cyc, 64'd19);
    exp_d("addq", cyc + 1, 1, 3'd1, 4'h6, 4'h0, 4'h0, 4'h1, 64'h0, 64'd21);
    step();
    pipe_defaults();

    exp_f("fpc_after_addq", cyc, 64'd21);
    exp_d("ret", cyc + 1, 1, 3'd1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'd22);
    step();

    W_icode = 4'h9; W_valM = 64'd30;
    exp_f("ret_redirect", cyc, 64'd30);
    exp_d("invalid_ins", cyc + 1, 1, 3'd4, 4'hE, 4'h0, 4'hF, 4'hF, 64'h0, 64'd31);
    step();
    pipe_defaults();

    exp_f("fpc_after_ins", cyc, 64'd31);
    F_stall = 1'b1; D_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      exp_f("stall_fpc", cyc, 64'd31);
      exp_d("stall_d", cyc, 1, 3'd4, 4'hE, 4'h0, 4'hF, 4'hF, 64'h0, 64'd31);
    end
    D_bubble = 1'b1;
    step();
    exp_d("stall_over_bubble", cyc, 1, 3'd4, 4'hE, 4'h0, 4'hF, 4'hF, 64'h0, 64'd31);
    D_stall = 1'b0;
    step();
    exp_d("bubble", cyc, 1, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    exp_f("bubble_fpc", cyc, 64'd31);
    F_stall = 1'b0; D_bubble = 1'b0;
    exp_d("ret_after_stall", cyc + 1, 1, 3'd1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'd32);
    step();

    M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'd1019;
    exp_f("redirect_to_end", cyc, 64'd1019);
    exp_d("adr_overrun", cyc + 1, 2, 3'd3, 4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0);
    step();
    pipe_defaults();

    W_icode = 4'h9; W_valM = 64'h100;
    exp_f("ret_to_halt", cyc, 64'h100);
    exp_d("halt", cyc + 1, 1, 3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h101);
    step();
    pipe_defaults();

    exp_f("fpc_after_halt", cyc, 64'h101);
    imem_we = 1'b1; imem_waddr = 10'd257; imem_wdata = 8'h10; F_stall = 1'b1;
    exp_d("old_byte_seen", cyc + 1, 1, 3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h102);
    step();
    imem_we = 1'b0; F_stall = 1'b0;
    exp_f("fpc_held", cyc, 64'h101);
    exp_d("new_byte_seen", cyc + 1, 1, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h102);
    step();

    rst_n = 1'b0;
    step();
    exp_d("midrun_reset_bubble", cyc, 1, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    exp_f("midrun_reset_fpc", cyc, 64'h0);
    rst_n = 1'b1;
    exp_d("mem_survives_reset", cyc + 1, 1, 3'd1, 4'h3, 4'h0, 4'hF, 4'h0, 64'd10, 64'd10);
    step();
    exp_f("fpc_after_reset", cyc, 64'd10);
    step();
    step();

    while (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: never checked, due cycle %0d now %0d", sb[0].name, sb[0].due, cyc);
      sb.delete(0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
